// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM. It deserialises 10-bit command
// frames onto rx_data/rx_valid and serialises read-data bytes back onto MISO.
module spi_slave_if #(
  parameter int FRAME_BITS = 10,
  parameter int TX_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [TX_BITS-1:0]    tx_data,
  input  logic                  tx_valid
);

  localparam int CW  = $clog2(FRAME_BITS);
  localparam int TCW = $clog2(TX_BITS);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [FRAME_BITS-2:0] rx_shift;
  logic [TX_BITS-2:0]    tx_shift;
  logic [TCW-1:0]        tx_cnt;
  logic                  addr_received;
  logic                  frame_done;
  logic                  tx_busy;
  logic                  tx_sent;

  // rx_shift holds frame bits [9:1]; bit 0 is taken straight from MOSI on the
  // completing edge. tx_shift holds only the bits still to go after MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_cnt        <= '0;
      addr_received <= 1'b0;
      frame_done    <= 1'b0;
      tx_busy       <= 1'b0;
      tx_sent       <= 1'b0;
      MISO          <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        tx_shift   <= '0;
        tx_cnt     <= '0;
        frame_done <= 1'b0;
        tx_busy    <= 1'b0;
        tx_sent    <= 1'b0;
        MISO       <= 1'b0;
        // last bit of the byte already on MISO: the read counts as done
        if (tx_busy && tx_cnt == '0)
          addr_received <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n)
              state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_shift <= {{(FRAME_BITS-2){1'b0}}, MOSI};
            bit_cnt  <= CW'(FRAME_BITS - 2);
            if (!MOSI)
              state <= WRITE;
            else if (addr_received)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              rx_shift <= {rx_shift[FRAME_BITS-3:0], MOSI};
              if (bit_cnt == '0) begin
                rx_data    <= {rx_shift, MOSI};
                rx_valid   <= 1'b1;
                frame_done <= 1'b1;
                if (state == READ_ADD)
                  addr_received <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end else if (state == READ_DATA) begin
              if (tx_busy) begin
                if (tx_cnt != '0) begin
                  MISO     <= tx_shift[TX_BITS-2];
                  tx_shift <= {tx_shift[TX_BITS-3:0], 1'b0};
                  tx_cnt   <= tx_cnt - 1'b1;
                end else begin
                  MISO          <= 1'b0;
                  tx_shift      <= '0;
                  tx_busy       <= 1'b0;
                  tx_sent       <= 1'b1;
                  addr_received <= 1'b0;
                end
              end else if (!tx_sent && tx_valid) begin
                tx_shift <= tx_data[TX_BITS-2:0];
                MISO     <= tx_data[TX_BITS-1];
                tx_cnt   <= TCW'(TX_BITS - 1);
                tx_busy  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised scoreboard bench for spi_slave_if: a frame-level model predicts
// rx_valid, rx_data and MISO for every clock edge.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;

  spi_slave_if #(.FRAME_BITS(10), .TX_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rxv;
    logic       miso;
    logic [9:0] rxd;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] frame_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  // model state
  logic [9:0] last_rx = '0;
  bit         addr_rcvd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // one clock edge of stimulus plus what the DUT must show after that edge
  task automatic step(input logic ss, input logic mosi, input logic txv,
                      input logic [7:0] txd, input logic ex_rxv, input logic ex_miso);
    exp_t e;
    @(negedge clk);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = txv;
    tx_data  = txd;
    e.rxv  = ex_rxv;
    e.miso = ex_miso;
    e.rxd  = last_rx;
    exp_q.push_back(e);
  endtask

  // mode: 0 write, 1 read-address, 2 read-data
  task automatic run_frame(input logic [9:0] f, input int nbits, input int hold_after,
                           input bit do_tx, input int tx_gap, input logic [7:0] txb,
                           input bit close);
    int         mode;
    logic       txv;
    logic       mb;
    logic [7:0] txd;
    mode = !f[9] ? 0 : (addr_rcvd ? 2 : 1);
    step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == 9) begin
        last_rx = f;
        frame_q.push_back(f);
        if (mode == 1) addr_rcvd = 1'b1;
      end
      step(1'b0, f[9-i], 1'($urandom), 8'($urandom), i == 9, 1'b0);
    end
    if (nbits == 10) begin
      for (int p = 0; p < hold_after; p++) begin
        txv = 1'($urandom);
        txd = 8'($urandom);
        mb  = 1'b0;
        if (mode == 2) begin
          if (do_tx && p == tx_gap) begin
            txv = 1'b1;
            txd = txb;
          end else if (!do_tx || p < tx_gap) begin
            txv = 1'b0;
          end
          if (do_tx && p >= tx_gap && p < tx_gap + 8) mb = txb[7-(p-tx_gap)];
          if (do_tx && p == tx_gap + 8) addr_rcvd = 1'b0;
        end
        step(1'b0, 1'($urandom), txv, txd, 1'b0, mb);
      end
      if (mode == 2 && do_tx && hold_after == tx_gap + 8) addr_rcvd = 1'b0;
    end
    if (close) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    rst      = 1'b0;
    last_rx   = '0;
    addr_rcvd = 1'b0;
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  // monitor: one expected entry per edge, frames popped on rx_valid
  exp_t       mon_e;
  logic [9:0] mon_f;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("rx_valid", 32'(rx_valid), 32'(mon_e.rxv));
      check("miso", 32'(MISO), 32'(mon_e.miso));
      check("rx_data_hold", 32'(rx_data), 32'(mon_e.rxd));
      if (mon_e.rxv && frame_q.size() != 0) begin
        mon_f = frame_q.pop_front();
        check("frame", 32'(rx_data), 32'(mon_f));
      end
    end
  end

  initial begin
    logic [9:0] f;
    int         nbits, gap, hold;
    bit         dtx;
    #2;
    rst = 1'b1;
    #1;
    check("init_rx_valid", 32'(rx_valid), 32'd0);
    check("init_miso", 32'(MISO), 32'd0);
    check("init_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);

    run_frame(10'h0A5, 10, 2, 0, 0, 8'h00, 1);
    run_frame(10'h13C, 10, 0, 0, 0, 8'h00, 1);
    async_reset();
    run_frame(10'h2A5, 10, 1, 0, 0, 8'h00, 1);
    run_frame(10'h300, 10, 10, 1, 0, 8'hC3, 1);
    run_frame(10'h0F0, 6, 0, 0, 0, 8'h00, 1);
    run_frame(10'h001, 10, 0, 0, 0, 8'h00, 1);
    run_frame(10'h2A5, 10, 0, 0, 0, 8'h00, 1);
    run_frame(10'h3C0, 10, 20, 0, 0, 8'h00, 1);
    run_frame(10'h35A, 10, 12, 1, 2, 8'h96, 1);
    run_frame(10'h055, 10, 4, 0, 0, 8'h00, 1);

    for (int r = 0; r < 60; r++) begin
      f     = 10'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10;
      dtx   = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 3);
      if (dtx)
        hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, gap + 8))
                                           : gap + 8 + int'($urandom_range(0, 3));
      else
        hold = $urandom_range(0, 6);
      run_frame(f, nbits, hold, dtx, gap, 8'($urandom), 1);
    end

    async_reset();
    run_frame(10'h2F0, 10, 0, 0, 0, 8'h00, 1);
    run_frame(10'h3AA, 10, 5, 1, 1, 8'hFF, 0);
    async_reset();
    run_frame(10'h3AA, 10, 3, 0, 0, 8'h00, 1);

    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("frames_left", 32'(frame_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
